// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default
// timing parameters and small helpers used by the sequencer logic.
package reset_sequencer_pkg;

    localparam int NUM_STAGES          = 3;
    localparam int DEFAULT_HOLD_CYCLES = 10;
    localparam int DEFAULT_ACK_TIMEOUT = 255;
    localparam int CNT_W               = 8;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        REL0  = 3'd1,
        REL1  = 3'd2,
        REL2  = 3'd3,
        RUN   = 3'd4,
        FAULT = 3'd5
    } seq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        result = (value == '1) ? value : value + 1'b1;
        return result;
    endfunction

    // Active-low stage reset pattern that belongs to each state.
    function automatic logic [NUM_STAGES-1:0] stage_mask(input seq_state_t s);
        logic [NUM_STAGES-1:0] mask;
        mask = 3'b000;
        case (s)
            REL0:      mask = 3'b001;
            REL1:      mask = 3'b011;
            REL2, RUN: mask = 3'b111;
            default:   mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/reset_sequencer_reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts on the second
// clock edge after the external reset is released.
module reset_sync (
    input  logic CLK,
    input  logic Reset_L,
    output logic rst_n_sync
);

    logic meta;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            meta       <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_n_sync <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds all stages in reset, then releases them
// one at a time, waiting for each stage's init acknowledge before moving on.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic                  SwReset_Req,
    input  logic [NUM_STAGES-1:0] Init_Done,
    output logic [NUM_STAGES-1:0] Stage_Rst_L,
    output logic                  Sys_Ready,
    output logic                  Fault,
    output logic [2:0]            Seq_State
);

    // Both limits name the counter value seen on the last cycle, so HOLD lasts
    // exactly HOLD_CYCLES cycles and a stage gets exactly ACK_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic                  rst_n;
    seq_state_t            state;
    seq_state_t            next_state;
    seq_state_t            advance_state;
    logic [CNT_W-1:0]      hold_cnt;
    logic [CNT_W-1:0]      hold_cnt_next;
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      wait_cnt_next;
    logic                  waiting;
    logic                  ack;

    reset_sync u_reset_sync (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .rst_n_sync (rst_n)
    );

    always_comb begin
        next_state    = state;
        advance_state = HOLD;
        hold_cnt_next = '0;
        wait_cnt_next = '0;
        waiting       = 1'b0;
        ack           = 1'b0;

        case (state)
            HOLD: begin
                if (hold_cnt >= HOLD_LAST) next_state = REL0;
                else                       hold_cnt_next = sat_inc(hold_cnt);
            end
            REL0: begin
                waiting       = 1'b1;
                ack           = Init_Done[0];
                advance_state = REL1;
            end
            REL1: begin
                waiting       = 1'b1;
                ack           = Init_Done[1];
                advance_state = REL2;
            end
            REL2: begin
                waiting       = 1'b1;
                ack           = Init_Done[2];
                advance_state = RUN;
            end
            RUN, FAULT: next_state = state;
            default:    next_state = HOLD;
        endcase

        // An acknowledge on the final timeout cycle still counts as success.
        if (waiting) begin
            if (ack)                        next_state = advance_state;
            else if (wait_cnt >= WAIT_LAST) next_state = FAULT;
            else                            wait_cnt_next = sat_inc(wait_cnt);
        end

        if (SwReset_Req) begin
            next_state    = HOLD;
            hold_cnt_next = '0;
            wait_cnt_next = '0;
        end
    end

    // Outputs come from next_state so they flip on the same edge as the state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            Stage_Rst_L <= '0;
            Sys_Ready   <= 1'b0;
            Fault       <= 1'b0;
        end else begin
            state       <= next_state;
            hold_cnt    <= hold_cnt_next;
            wait_cnt    <= wait_cnt_next;
            Stage_Rst_L <= stage_mask(next_state);
            Sys_Ready   <= (next_state == RUN);
            Fault       <= (next_state == FAULT);
        end
    end

    assign Seq_State = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, slow acks, timeouts,
// software reset and asynchronous abort, each checked against hand values.
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       Reset_L;
    logic       SwReset_Req;
    logic [2:0] Init_Done;
    logic [2:0] Stage_Rst_L;
    logic       Sys_Ready;
    logic       Fault;
    logic [2:0] Seq_State;

    int total = 0;
    int bad   = 0;

    // Observation word: {state, stage resets, ready, fault}.
    wire [7:0] obs = {Seq_State, Stage_Rst_L, Sys_Ready, Fault};

    localparam logic [7:0] O_HOLD  = 8'b000_000_0_0;
    localparam logic [7:0] O_REL0  = 8'b001_001_0_0;
    localparam logic [7:0] O_REL1  = 8'b010_011_0_0;
    localparam logic [7:0] O_REL2  = 8'b011_111_0_0;
    localparam logic [7:0] O_RUN   = 8'b100_111_1_0;
    localparam logic [7:0] O_FAULT = 8'b101_000_0_1;

    always #5 CLK = ~CLK;

    reset_sequencer #(
        .HOLD_CYCLES (10),
        .ACK_TIMEOUT (255)
    ) dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .SwReset_Req (SwReset_Req),
        .Init_Done   (Init_Done),
        .Stage_Rst_L (Stage_Rst_L),
        .Sys_Ready   (Sys_Ready),
        .Fault       (Fault),
        .Seq_State   (Seq_State)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Pulse the master reset, release it and let the synchroniser finish.
    task automatic restart(input logic [2:0] ack);
        Reset_L     = 1'b0;
        SwReset_Req = 1'b0;
        Init_Done   = ack;
        tick(2);
        Reset_L = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        Reset_L     = 1'b0;
        SwReset_Req = 1'b0;
        Init_Done   = 3'b111;
        #1;
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL reset_async obs=%b exp=%b", obs, O_HOLD); end
        tick(2);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL reset_held obs=%b exp=%b", obs, O_HOLD); end
    endtask

    task automatic test_power_up();
        restart(3'b111);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL pwr_sync obs=%b exp=%b", obs, O_HOLD); end
        for (int i = 0; i < 9; i++) begin
            tick(1);
            total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL pwr_hold%0d obs=%b exp=%b", i, obs, O_HOLD); end
        end
        tick(1);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL pwr_rel0 obs=%b exp=%b", obs, O_REL0); end
        tick(1);
        total++; if (obs !== O_REL1) begin bad++; $display("[TB] FAIL pwr_rel1 obs=%b exp=%b", obs, O_REL1); end
        tick(1);
        total++; if (obs !== O_REL2) begin bad++; $display("[TB] FAIL pwr_rel2 obs=%b exp=%b", obs, O_REL2); end
        tick(1);
        total++; if (obs !== O_RUN) begin bad++; $display("[TB] FAIL pwr_run obs=%b exp=%b", obs, O_RUN); end
    endtask

    task automatic test_slow_ack();
        restart(3'b100);
        tick(10);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL slow_rel0 obs=%b exp=%b", obs, O_REL0); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL slow_ignore%0d obs=%b exp=%b", i, obs, O_REL0); end
        end
        Init_Done = 3'b101;
        tick(1);
        total++; if (obs !== O_REL1) begin bad++; $display("[TB] FAIL slow_enter_rel1 obs=%b exp=%b", obs, O_REL1); end
        for (int i = 0; i < 19; i++) begin
            tick(1);
            total++; if (obs !== O_REL1) begin bad++; $display("[TB] FAIL slow_wait%0d obs=%b exp=%b", i, obs, O_REL1); end
        end
        Init_Done = 3'b111;
        tick(1);
        total++; if (obs !== O_REL2) begin bad++; $display("[TB] FAIL slow_rel2 obs=%b exp=%b", obs, O_REL2); end
        tick(1);
        total++; if (obs !== O_RUN) begin bad++; $display("[TB] FAIL slow_run obs=%b exp=%b", obs, O_RUN); end
    endtask

    task automatic test_timeout();
        restart(3'b000);
        tick(10);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL to_rel0 obs=%b exp=%b", obs, O_REL0); end
        tick(254);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL to_last_wait obs=%b exp=%b", obs, O_REL0); end
        tick(1);
        total++; if (obs !== O_FAULT) begin bad++; $display("[TB] FAIL to_fault obs=%b exp=%b", obs, O_FAULT); end
        Init_Done = 3'b111;
        tick(3);
        total++; if (obs !== O_FAULT) begin bad++; $display("[TB] FAIL to_fault_sticky obs=%b exp=%b", obs, O_FAULT); end
        SwReset_Req = 1'b1;
        tick(1);
        SwReset_Req = 1'b0;
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL to_sw_hold obs=%b exp=%b", obs, O_HOLD); end
        tick(9);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL to_sw_hold_end obs=%b exp=%b", obs, O_HOLD); end
        tick(1);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL to_sw_rel0 obs=%b exp=%b", obs, O_REL0); end
        tick(3);
        total++; if (obs !== O_RUN) begin bad++; $display("[TB] FAIL to_sw_run obs=%b exp=%b", obs, O_RUN); end
    endtask

    task automatic test_timeout_boundary();
        restart(3'b000);
        tick(10);
        tick(254);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL edge_rel0_wait obs=%b exp=%b", obs, O_REL0); end
        Init_Done = 3'b001;
        tick(1);
        total++; if (obs !== O_REL1) begin bad++; $display("[TB] FAIL edge_rel0_ack obs=%b exp=%b", obs, O_REL1); end
        tick(254);
        total++; if (obs !== O_REL1) begin bad++; $display("[TB] FAIL edge_rel1_wait obs=%b exp=%b", obs, O_REL1); end
        Init_Done = 3'b011;
        tick(1);
        total++; if (obs !== O_REL2) begin bad++; $display("[TB] FAIL edge_rel1_ack obs=%b exp=%b", obs, O_REL2); end
        tick(254);
        total++; if (obs !== O_REL2) begin bad++; $display("[TB] FAIL edge_rel2_wait obs=%b exp=%b", obs, O_REL2); end
        tick(1);
        total++; if (obs !== O_FAULT) begin bad++; $display("[TB] FAIL edge_rel2_fault obs=%b exp=%b", obs, O_FAULT); end
    endtask

    task automatic test_back_to_back();
        restart(3'b111);
        tick(13);
        total++; if (obs !== O_RUN) begin bad++; $display("[TB] FAIL b2b_run obs=%b exp=%b", obs, O_RUN); end
        SwReset_Req = 1'b1;
        tick(1);
        SwReset_Req = 1'b0;
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL b2b_sw_from_run obs=%b exp=%b", obs, O_HOLD); end
        tick(9);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL b2b_hold_end obs=%b exp=%b", obs, O_HOLD); end
        tick(1);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL b2b_rel0 obs=%b exp=%b", obs, O_REL0); end
        tick(3);
        total++; if (obs !== O_RUN) begin bad++; $display("[TB] FAIL b2b_run_again obs=%b exp=%b", obs, O_RUN); end
        SwReset_Req = 1'b1;
        tick(1);
        SwReset_Req = 1'b0;
        tick(5);
        SwReset_Req = 1'b1;
        tick(1);
        SwReset_Req = 1'b0;
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL b2b_sw_in_hold obs=%b exp=%b", obs, O_HOLD); end
        tick(9);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL b2b_hold_restart obs=%b exp=%b", obs, O_HOLD); end
        tick(1);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL b2b_rel0_after_restart obs=%b exp=%b", obs, O_REL0); end
    endtask

    task automatic test_async_abort();
        restart(3'b001);
        tick(11);
        total++; if (obs !== O_REL1) begin bad++; $display("[TB] FAIL abort_rel1 obs=%b exp=%b", obs, O_REL1); end
        tick(3);
        #3;
        Reset_L = 1'b0;
        #1;
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL abort_immediate obs=%b exp=%b", obs, O_HOLD); end
        tick(1);
        Reset_L   = 1'b1;
        Init_Done = 3'b111;
        tick(2);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL abort_sync obs=%b exp=%b", obs, O_HOLD); end
        tick(9);
        total++; if (obs !== O_HOLD) begin bad++; $display("[TB] FAIL abort_hold_end obs=%b exp=%b", obs, O_HOLD); end
        tick(1);
        total++; if (obs !== O_REL0) begin bad++; $display("[TB] FAIL abort_rel0 obs=%b exp=%b", obs, O_REL0); end
        tick(3);
        total++; if (obs !== O_RUN) begin bad++; $display("[TB] FAIL abort_run obs=%b exp=%b", obs, O_RUN); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_slow_ack();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_async_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog obs=%b exp=finished", obs);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, cycles all stage resets stay asserted after reset release or software reset.
REQ-002 Parameter ACK_TIMEOUT, default 255, maximum cycles to wait for a stage's Init_Done before fault.
REQ-003 Parameter NUM_STAGES, fixed 3, stages released in order 0 (memory), 1 (register file), 2 (PC/fetch).
REQ-004 CLK  input  1  single clock; all state changes on posedge.
REQ-005 Reset_L  input  1  asynchronous, active-low master reset.
REQ-006 SwReset_Req  input  1  synchronous software reset request, sampled each cycle.
REQ-007 Init_Done  input  3  per-stage initialisation-complete acknowledge, level, bit i for stage i.
REQ-008 Stage_Rst_L  output  3  per-stage active-low reset; bit i drives stage i.
REQ-009 Sys_Ready  output  1  high only in RUN.
REQ-010 Fault  output  1  high only in FAULT.
REQ-011 Seq_State  output  3  current FSM state encoding, for debug.

Function
REQ-012 FSM states SHALL be HOLD, REL0, REL1, REL2, RUN, FAULT.
REQ-013 HOLD: Stage_Rst_L=000; 8-bit hold counter increments each cycle; after exactly HOLD_CYCLES cycles in HOLD, next state REL0.
REQ-014 RELi: stages 0..i deasserted (Stage_Rst_L bits 0..i = 1), stages above i asserted; wait counter increments each cycle.
REQ-015 RELi exit: Init_Done[i]=1 sampled -> next state REL(i+1), or RUN from REL2; wait counter cleared on every state change.
REQ-016 RELi timeout: wait counter reaching ACK_TIMEOUT with Init_Done[i]=0 -> FAULT; Init_Done[i]=1 in that same cycle takes priority (advance, no fault).
REQ-017 Init_Done bits for stages other than the one being waited on SHALL be ignored.
REQ-018 RUN: Stage_Rst_L=111, Sys_Ready=1; stays until SwReset_Req.
REQ-019 FAULT: Stage_Rst_L=000, Fault=1; exits only via SwReset_Req or Reset_L.
REQ-020 SwReset_Req=1 in any state SHALL force next state HOLD with hold counter cleared (restart of hold period, including when already in HOLD).
REQ-021 Stage_Rst_L, Sys_Ready, Fault SHALL be registered outputs decoded from next state, so they change on the same edge as the state.
REQ-022 Counters SHALL saturate, never wrap.

Reset
REQ-023 Reset_L low SHALL immediately (asynchronously) force state HOLD, counters 0, Stage_Rst_L=000, Sys_Ready=0, Fault=0.
REQ-024 Reset_L deassertion SHALL be synchronised through a two-flop synchroniser; internal logic leaves reset on the second CLK posedge after Reset_L rises.
REQ-025 Reset_L asserted mid-sequence (any state) SHALL abort the sequence with the REQ-023 values; no partial release survives.

Structure
REQ-026 State encoding constants (HOLD=0, REL0=1, REL1=2, REL2=3, RUN=4, FAULT=5) and default parameter values SHALL live in the shared project package.
REQ-027 The reset synchroniser SHALL be a separate sub-module reset_sync (async assert, two-flop sync deassert).

Verification
REQ-028 Reset_L low then high, Init_Done=111 constant -> Stage_Rst_L 000 for 10 cycles after sync, then 001, 011, 111 on consecutive cycles; Sys_Ready=1.
REQ-029 Init_Done[1] raised 20 cycles after entering REL1 -> Stage_Rst_L=011 held 20 cycles, then 111; Fault stays 0.
REQ-030 Init_Done[0] never raised -> FAULT after 255 cycles in REL0; Stage_Rst_L=000, Fault=1; SwReset_Req then -> HOLD, Fault=0.
REQ-031 SwReset_Req pulse in RUN -> Stage_Rst_L=000 next edge, full 10-cycle hold and release replayed.
REQ-032 Reset_L pulled low during REL1 -> Stage_Rst_L=000 immediately, before next CLK edge; sequence restarts from HOLD.
REQ-033 Init_Done[i] rising on exactly the timeout cycle -> advance, no Fault.
